fw_wb_master: RTL and testbench

//  Wishbone classic initiator for the firmware test harness. Accepts one register request at a time on a

---
 rtl/fw_wb_master.sv | 205 ++++++++++++++++++++
 tb/tb_fw_wb_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_wb_master.sv
// fw_wb_master: Wishbone classic initiator. Takes a single register request on a valid/ready
// port. Runs one classic cycle with bounded RTY retries and a watchdog timeout. Returns the
// status and the read data on a valid/ready response port.
// Ports:
//   wb_clk_i, wb_rst_n_i              clock, async active-low reset
//   req_valid_i/req_ready_o/req_*     request port (we, byte address, write data, selects)
//   rsp_valid_o/rsp_ready_i/rsp_*     response port (read data, 2-bit status)
//   wb_*_o / wb_*_i                   Wishbone classic initiator interface
module fw_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned RETRY_GAP      = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    input  logic [3:0]  req_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic [1:0]  rsp_sts_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GapW = $clog2(RETRY_GAP + 1);

    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [RtyW-1:0] RtyMax  = RtyW'(MAX_RETRY);
    localparam logic [GapW-1:0] GapLast = GapW'(RETRY_GAP - 1);

    localparam logic [1:0] StsOk  = 2'b00;
    localparam logic [1:0] StsErr = 2'b01;
    localparam logic [1:0] StsRty = 2'b10;
    localparam logic [1:0] StsTmo = 2'b11;

    typedef enum logic [1:0] {StIdle, StBus, StGap, StResp} state_e;

    state_e          state_q, state_d;
    logic            req_ready_q, req_ready_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [3:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_dat_q, rsp_dat_d;
    logic [1:0]      rsp_sts_q, rsp_sts_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [RtyW-1:0] rty_cnt_q, rty_cnt_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_sts_d   = rsp_sts_q;
        tmo_cnt_d   = tmo_cnt_q;
        rty_cnt_d   = rty_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    adr_d     = req_adr_i;
                    dat_d     = req_dat_i;
                    sel_d     = req_sel_i;
                    we_d      = req_we_i;
                    tmo_cnt_d = '0;
                    rty_cnt_d = '0;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    state_d   = StBus;
                end
            end
            StBus: begin
                // Any termination drops cyc/stb on the sampling edge itself.
                if (wb_err_i || wb_rty_i || wb_ack_i || tmo_cnt_q == TmoLast) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                end
                if (wb_err_i) begin
                    rsp_sts_d   = StsErr;
                    rsp_dat_d   = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else if (wb_rty_i) begin
                    if (rty_cnt_q < RtyMax) begin
                        rty_cnt_d = rty_cnt_q + 1'b1;
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else begin
                        rsp_sts_d   = StsRty;
                        rsp_dat_d   = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = StResp;
                    end
                end else if (wb_ack_i) begin
                    rsp_sts_d   = StsOk;
                    rsp_dat_d   = we_q ? 32'h0 : wb_dat_i;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else if (tmo_cnt_q == TmoLast) begin
                    rsp_sts_d   = StsTmo;
                    rsp_dat_d   = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    tmo_cnt_d = '0;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    state_d   = StBus;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered so that ready stays low while reset is asserted.
        req_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_sts_q   <= '0;
            tmo_cnt_q   <= '0;
            rty_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_sts_q   <= rsp_sts_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rty_cnt_q   <= rty_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_sts_o   = rsp_sts_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign wb_we_o     = we_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_cti_o    = 3'b000;
    assign wb_bte_o    = 2'b00;

endmodule

// File: tb/tb_fw_wb_master.sv
// tb_fw_wb_master: directed and random transactions against fw_wb_master. A behavioural
// Wishbone responder (registered ack, with modes for ack+err, N retries and silence) drives the
// DUT. Expected status, data, attempt count and strobe length come from a high-level model.
module tb_fw_wb_master;

    localparam int Tmo  = 64;
    localparam int MaxR = 3;
    localparam int Gap  = 2;

    localparam int ModeAck    = 0;
    localparam int ModeAckErr = 1;
    localparam int ModeRty    = 2;
    localparam int ModeNone   = 3;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_sts;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_rty;

    int checks = 0;
    int errors = 0;

    // Responder configuration, written only by the stimulus block.
    int mode       = ModeAck;
    int rty_target = 0;
    int base_pulses = 0;

    // Bus monitor counters, written only by the monitor block.
    int   pulses    = 0;
    int   hi_cycles = 0;
    int   acks      = 0;
    int   low_run   = 0;
    int   last_gap  = 0;
    logic stb_prev  = 1'b0;

    logic [31:0] mem [256];
    logic [31:0] model_mem [256];

    fw_wb_master dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_adr_i   (req_adr),
        .req_dat_i   (req_dat),
        .req_sel_i   (req_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_sts_o   (rsp_sts),
        .wb_adr_o    (wb_adr),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel),
        .wb_we_o     (wb_we),
        .wb_cyc_o    (wb_cyc),
        .wb_stb_o    (wb_stb),
        .wb_cti_o    (wb_cti),
        .wb_bte_o    (wb_bte),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack),
        .wb_err_i    (wb_err),
        .wb_rty_i    (wb_rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (wb_stb) hi_cycles <= hi_cycles + 1;
        if (wb_ack) acks <= acks + 1;
        if (!wb_stb) begin
            low_run <= low_run + 1;
        end else if (!stb_prev) begin
            pulses   <= pulses + 1;
            last_gap <= low_run;
            low_run  <= 0;
        end
        stb_prev <= wb_stb;
    end

    // Registered responder: answers once per strobe pulse, one cycle after it rises.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_err   <= 1'b0;
            wb_rty   <= 1'b0;
            wb_dat_i <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            wb_rty <= 1'b0;
            if (wb_cyc && wb_stb && !stb_prev) begin
                wb_dat_i <= $urandom;
                if (mode == ModeAckErr) begin
                    wb_ack <= 1'b1;
                    wb_err <= 1'b1;
                end else if (mode == ModeRty && (pulses - base_pulses) < rty_target) begin
                    wb_rty <= 1'b1;
                end else if (mode == ModeAck || mode == ModeRty) begin
                    wb_ack <= 1'b1;
                    if (wb_we) mem[wb_adr[9:2]] <= merge(mem[wb_adr[9:2]], wb_dat_o, wb_sel);
                    else wb_dat_i <= mem[wb_adr[9:2]];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int md, input int tgt, input int hold);
        int          n;
        int          p0, h0, a0;
        int          exp_pulses, exp_hi, exp_acks;
        logic [1:0]  exp_sts;
        logic [31:0] exp_dat;
        logic [31:0] hold_dat;
        logic [1:0]  hold_sts;

        // Reference model: outcome follows directly from the responder behaviour.
        if (md == ModeAck) begin
            exp_sts = 2'b00; exp_pulses = 1;
        end else if (md == ModeAckErr) begin
            exp_sts = 2'b01; exp_pulses = 1;
        end else if (md == ModeRty) begin
            if (tgt <= MaxR) begin exp_sts = 2'b00; exp_pulses = tgt + 1; end
            else begin exp_sts = 2'b10; exp_pulses = MaxR + 1; end
        end else begin
            exp_sts = 2'b11; exp_pulses = 1;
        end
        exp_hi   = (md == ModeNone) ? Tmo : 2 * exp_pulses;
        exp_acks = (exp_sts == 2'b00 || md == ModeAckErr) ? 1 : 0;
        exp_dat  = (exp_sts == 2'b00 && !we) ? model_mem[adr[9:2]] : 32'h0;
        if (exp_sts == 2'b00 && we) model_mem[adr[9:2]] = merge(model_mem[adr[9:2]], dat, sel);

        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("req_ready_idle", {31'b0, req_ready}, 32'h1);

        mode = md;
        rty_target = tgt;
        base_pulses = pulses;
        p0 = pulses; h0 = hi_cycles; a0 = acks;
        req_we = we; req_adr = adr; req_dat = dat; req_sel = sel; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_we = $urandom; req_adr = $urandom; req_dat = $urandom; req_sel = 4'($urandom);

        n = 0;
        while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
        check("rsp_arrived", {31'b0, rsp_valid}, 32'h1);
        check("rsp_sts", {30'b0, rsp_sts}, {30'b0, exp_sts});
        check("rsp_dat", rsp_dat, exp_dat);
        check("cyc_low_at_rsp", {30'b0, wb_cyc, wb_stb}, 32'h0);
        check("attempts", 32'(pulses - p0), 32'(exp_pulses));
        check("stb_hi_cycles", 32'(hi_cycles - h0), 32'(exp_hi));
        check("ack_count", 32'(acks - a0), 32'(exp_acks));
        if (exp_pulses > 1) check("retry_gap", 32'(last_gap), 32'(Gap));

        hold_dat = rsp_dat;
        hold_sts = rsp_sts;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'b0, rsp_valid}, 32'h1);
            check("hold_dat", rsp_dat, hold_dat);
            check("hold_sts", {30'b0, rsp_sts}, {30'b0, hold_sts});
            check("hold_no_ready", {31'b0, req_ready}, 32'h0);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_dropped", {31'b0, rsp_valid}, 32'h0);
        check("ready_after_rsp", {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        int r;
        logic [31:0] a;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        #23;
        check("rst_cyc_stb", {30'b0, wb_cyc, wb_stb}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check("rst_wb_adr", wb_adr, 32'h0);
        check("rst_rsp_dat", rsp_dat, 32'h0);
        check("cti_bte", {27'b0, wb_cti, wb_bte}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_reset", {31'b0, req_ready}, 32'h1);

        // Directed cases.
        txn(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, ModeAck, 0, 0);
        txn(1'b0, 32'h4, 32'h0, 4'hF, ModeAck, 0, 0);
        txn(1'b0, 32'h400, 32'h0, 4'hF, ModeAckErr, 0, 0);
        txn(1'b1, 32'h8, 32'h12345678, 4'hF, ModeRty, 2, 0);
        txn(1'b0, 32'h8, 32'h0, 4'hF, ModeRty, 4, 0);
        txn(1'b0, 32'h8, 32'h0, 4'hF, ModeAck, 0, 0);
        txn(1'b0, 32'hC, 32'h0, 4'hF, ModeNone, 0, 0);
        txn(1'b0, 32'h4, 32'h0, 4'hF, ModeAck, 0, 10);
        txn(1'b1, 32'h4, 32'hA5A5A5A5, 4'h5, ModeAck, 0, 0);
        txn(1'b0, 32'h4, 32'h0, 4'hF, ModeAck, 0, 0);

        // Reset in the middle of a bus cycle.
        mode = ModeNone;
        req_we = 1'b0; req_adr = 32'h10; req_sel = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_bus_stb", {31'b0, wb_stb}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cyc_stb", {30'b0, wb_cyc, wb_stb}, 32'h0);
        check("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, ModeAck, 0, 0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, ModeAck, 0, 0);

        // Random traffic.
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 15)) << 2;
            if (r <= 5)
                txn(1'($urandom), a, $urandom, 4'($urandom), ModeAck, 0, $urandom_range(0, 3));
            else if (r == 6)
                txn(1'($urandom), a, $urandom, 4'hF, ModeAckErr, 0, 0);
            else
                txn(1'($urandom), a, $urandom, 4'($urandom), ModeRty, $urandom_range(0, 5), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
